mult_accum: RTL

- Downstream consumer of the 8-bit combinational multiplier's output.
- Takes the truncated 8-bit product (outWire) and its overflow flag (errorWire) term by term over a valid/ready handshake.
- Sums a programmed number of terms into a saturating accumulator; reports sticky multiplier-error and accumulator-overflow flags.
- Gives the ALU a sum-of-products (dot-product) operation.

---
 rtl/mult_accum_pkg.sv | 13 +
 rtl/sat_adder.sv | 21 ++
 rtl/mult_accum.sv | 88 ++++++++
 3 files changed

// File: rtl/mult_accum_pkg.sv
// Shared ALU definitions: FSM state encoding and the multiplier product width
// used by the sum-of-products accumulator.
package mult_accum_pkg;

    localparam int PRODUCT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/sat_adder.sv
// Unsigned ACC_W-bit accumulator plus a zero-extended product, clamped to the
// all-ones value when the sum carries out.
module sat_adder
    import mult_accum_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [PRODUCT_W-1:0] operand,
    output logic [ACC_W-1:0]     sum,
    output logic                 saturated
);

    logic [ACC_W:0] wide;

    // One extra bit holds the carry that signals saturation.
    assign wide      = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, operand};
    assign saturated = wide[ACC_W];
    assign sum       = saturated ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/mult_accum.sv
// Sum-of-products accumulator fed term by term from the 8-bit multiplier.
// Optional build macro MULT_ACCUM_ERR_DROP_EN: terms flagged as truncated are counted but not added.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     numTerms,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [PRODUCT_W-1:0] product,
    input  logic                 productError,
    output logic [ACC_W-1:0]     accOut,
    output logic                 busy,
    output logic                 done,
    output logic                 errorSticky,
    output logic                 overflow
);

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [PRODUCT_W-1:0]   addend;
    logic [ACC_W-1:0]       sum;
    logic                   saturated;
    logic                   accept;

    // Handshake and status depend on state alone, never on inValid.
    assign inReady = (state == ACCUM);
    assign busy    = (state == ACCUM);
    assign done    = (state == DONE);
    assign accept  = inValid & inReady;

`ifdef MULT_ACCUM_ERR_DROP_EN
    assign addend = productError ? '0 : product;
`else
    assign addend = product;
`endif

    sat_adder #(
        .ACC_W(ACC_W)
    ) u_sat_adder (
        .acc       (accOut),
        .operand   (addend),
        .sum       (sum),
        .saturated (saturated)
    );

    // NOTE: registers use non-blocking assignments so every update in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            accOut      <= '0;
            errorSticky <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accOut      <= '0;
                        errorSticky <= 1'b0;
                        overflow    <= 1'b0;
                        count       <= numTerms;
                        state       <= (numTerms != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        accOut      <= sum;
                        errorSticky <= errorSticky | productError;
                        overflow    <= overflow | saturated;
                        count       <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
